// File: rtl/mem_stream_port.sv
// Streams words between the byte link and the 512x12 program memory.
// Load packs two bytes per word (high nibble first); dump unpacks each word into two bytes.
module mem_stream_port #(
    parameter int AW = 9,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_load,
    input  logic          cmd_dump,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // rx: a byte moves when rx_valid && rx_ready at posedge.
    // tx: a byte moves when tx_valid && tx_ready at posedge; tx_data is held while tx_valid waits.
    typedef enum logic [3:0] {
        IDLE, L_HI, L_LO, L_WR, D_RD, D_WAIT, D_HI, D_LO, FIN
    } state_t;

    localparam logic [AW:0] ONE = 1;

    state_t      state;
    state_t      state_nx;
    logic [AW:0] count;
    logic [3:0]  nibble;
    logic [7:0]  word_lo;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = 1'b0;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        mem_wr   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_load)      state_nx = (len == '0) ? FIN : L_HI;
                else if (cmd_dump) state_nx = (len == '0) ? FIN : D_RD;
            end
            L_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nx = L_LO;
            end
            L_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nx = L_WR;
            end
            L_WR: begin
                // The memory captures this write on the falling edge inside the cycle.
                mem_wr   = 1'b1;
                state_nx = (count == ONE) ? FIN : L_HI;
            end
            D_RD:   state_nx = D_WAIT;
            D_WAIT: state_nx = D_HI;
            D_HI: begin
                tx_valid = 1'b1;
                if (tx_ready) state_nx = D_LO;
            end
            D_LO: begin
                tx_valid = 1'b1;
                if (tx_ready) state_nx = (count == ONE) ? FIN : D_RD;
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            tx_data   <= '0;
            count     <= '0;
            nibble    <= '0;
            word_lo   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_load || cmd_dump) begin
                        mem_addr <= base;
                        count    <= len;
                    end
                end
                L_HI: if (rx_valid) nibble <= rx_data[3:0];
                L_LO: if (rx_valid) mem_wdata <= {nibble, rx_data};
                L_WR: begin
                    mem_addr <= mem_addr + 1'b1;
                    count    <= count - 1'b1;
                end
                D_WAIT: begin
                    word_lo <= mem_rdata[7:0];
                    tx_data <= {4'b0000, mem_rdata[11:8]};
                end
                D_HI: if (tx_ready) tx_data <= word_lo;
                D_LO: begin
                    if (tx_ready) begin
                        mem_addr <= mem_addr + 1'b1;
                        count    <= count - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stream_port.sv
// Bench for mem_stream_port: falling-edge memory model, byte-stream drivers and a
// word-level reference (ref_mem + expected byte queue) checked with immediate assertions.
module tb_mem_stream_port;

    localparam int AW = 9;
    localparam int DW = 12;
    localparam int MAXCYC = 6000;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_load;
    logic          cmd_dump;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    mem_stream_port #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .cmd_load(cmd_load), .cmd_dump(cmd_dump),
        .base(base), .len(len), .busy(busy), .done(done),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    logic [DW-1:0] mem [512];
    logic [DW-1:0] ref_mem [512];
    logic [7:0]    src_q[$];
    logic [7:0]    exp_q[$];
    logic [7:0]    got_q[$];

    int   wr_cnt = 0;
    int   done_cnt = 0;
    int   rdy_cnt = 0;
    int   tv_cnt = 0;
    int   stab_err = 0;
    int   extra_take = 0;
    logic rx_take = 1'b0;
    logic hold_prev = 1'b0;
    logic [7:0] data_prev = '0;

    always @(negedge clk) begin
        if (mem_wr === 1'b1) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt++;
        end
        mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk) begin
        rx_take <= rx_valid && rx_ready;
        if (tx_valid === 1'b1 && tx_ready === 1'b1) got_q.push_back(tx_data);
        if (done === 1'b1) done_cnt++;
        if (rx_ready === 1'b1) rdy_cnt++;
        if (tx_valid === 1'b1) tv_cnt++;
        if (hold_prev === 1'b1 && (tx_valid !== 1'b1 || tx_data !== data_prev)) stab_err++;
        hold_prev <= tx_valid && !tx_ready;
        data_prev <= tx_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic mem_compare(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) bad++;
        check($sformatf("%s.mem_image_bad_words", tag), bad, 0);
    endtask

    task automatic run_op(input bit do_load, input bit both, input logic [AW-1:0] b,
                          input logic [AW:0] l, input int gap, input bit noise, input string tag);
        int d0, w0, r0, v0, cyc, n, want_cyc;
        logic [DW-1:0] w;
        n = int'(l);
        got_q.delete();
        exp_q.delete();
        if (do_load) begin
            if (src_q.size() == 0) for (int i = 0; i < 2 * n; i++) src_q.push_back(8'($urandom));
            for (int i = 0; i < n; i++) ref_mem[(int'(b) + i) % 512] = {src_q[2*i][3:0], src_q[2*i+1]};
            want_cyc = 3 * n + 1;
        end else begin
            for (int i = 0; i < n; i++) begin
                w = ref_mem[(int'(b) + i) % 512];
                exp_q.push_back({4'b0000, w[11:8]});
                exp_q.push_back(w[7:0]);
            end
            want_cyc = 4 * n + 1;
        end
        d0 = done_cnt; w0 = wr_cnt; r0 = rdy_cnt; v0 = tv_cnt;
        stab_err = 0; extra_take = 0;
        @(negedge clk);
        cmd_load = do_load; cmd_dump = !do_load || both; base = b; len = l;
        @(negedge clk);
        cmd_load = 0; cmd_dump = 0; base = AW'($urandom); len = (AW+1)'($urandom);
        check($sformatf("%s.busy_set", tag), busy, 1);
        cyc = 0;
        while (busy === 1'b1 && cyc < MAXCYC) begin
            if (rx_take === 1'b1) begin
                if (src_q.size() > 0) void'(src_q.pop_front());
                else extra_take++;
            end
            rx_valid = ($urandom_range(99) >= gap);
            rx_data  = (src_q.size() > 0) ? src_q[0] : 8'($urandom);
            tx_ready = ($urandom_range(99) >= gap);
            cmd_load = noise && ($urandom_range(7) == 0);
            cmd_dump = noise && ($urandom_range(7) == 0);
            @(negedge clk);
            cyc++;
        end
        rx_valid = 0; cmd_load = 0; cmd_dump = 0;
        check($sformatf("%s.finished", tag), cyc < MAXCYC, 1);
        if (gap == 0) check($sformatf("%s.cycles", tag), cyc, want_cyc);
        check($sformatf("%s.done_pulses", tag), done_cnt - d0, 1);
        check($sformatf("%s.mem_writes", tag), wr_cnt - w0, do_load ? n : 0);
        check($sformatf("%s.bytes_left", tag), src_q.size(), 0);
        check($sformatf("%s.extra_take", tag), extra_take, 0);
        check($sformatf("%s.tx_stable", tag), stab_err, 0);
        check($sformatf("%s.tx_count", tag), got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s.byte%0d", tag, i), got_q[i], exp_q[i]);
        if (do_load) check($sformatf("%s.tx_valid_cycles", tag), tv_cnt - v0, 0);
        else         check($sformatf("%s.rx_ready_cycles", tag), rdy_cnt - r0, 0);
        if (n == 0)  check($sformatf("%s.rx_ready_len0", tag), rdy_cnt - r0, 0);
        mem_compare(tag);
        src_q.delete();
    endtask

    initial begin
        int d0, w0, cyc;
        logic is_load;
        logic [AW:0] rl;
        rst = 1; cmd_load = 0; cmd_dump = 0; base = '0; len = '0;
        rx_valid = 0; rx_data = '0; tx_ready = 0;
        for (int i = 0; i < 512; i++) begin
            ref_mem[i] = (i >= 2 && i <= 5) ? DW'(i) : DW'($urandom);
            mem[i] <= ref_mem[i];
        end

        repeat (3) @(negedge clk);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.rx_ready", rx_ready, 0);
        check("reset.tx_valid", tx_valid, 0);
        check("reset.tx_data", tx_data, 0);
        check("reset.mem_addr", mem_addr, 0);
        check("reset.mem_wr", mem_wr, 0);
        check("reset.mem_wdata", mem_wdata, 0);
        rst = 0;

        src_q = '{8'h07, 8'h00, 8'h0A, 8'h05};
        run_op(1, 0, 9'd0, 10'd2, 0, 0, "load_basic");
        check("load_basic.mem0", mem[0], 12'h700);
        check("load_basic.mem1", mem[1], 12'hA05);

        run_op(0, 0, 9'd2, 10'd4, 0, 0, "dump_basic");
        check("dump_basic.last_byte", got_q[7], 8'h05);

        // Dump one word while the sink stalls.
        got_q.delete(); stab_err = 0; d0 = done_cnt; tx_ready = 0;
        @(negedge clk); cmd_dump = 1; base = 9'd3; len = 10'd1;
        @(negedge clk); cmd_dump = 0;
        cyc = 0;
        while (tx_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        check("stall.tx_valid_seen", cyc < 20, 1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall.valid%0d", i), tx_valid, 1);
            check($sformatf("stall.data%0d", i), tx_data, 8'h00);
            @(negedge clk);
        end
        check("stall.no_bytes_yet", got_q.size(), 0);
        tx_ready = 1;
        cyc = 0;
        while (busy === 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        check("stall.finished", cyc < 20, 1);
        check("stall.byte_count", got_q.size(), 2);
        check("stall.hi", got_q[0], 8'h00);
        check("stall.lo", got_q[1], 8'h03);
        check("stall.done", done_cnt - d0, 1);
        check("stall.stable", stab_err, 0);

        src_q = '{8'hF1, 8'h23, 8'h04, 8'h56};
        run_op(1, 0, 9'd511, 10'd2, 0, 0, "load_wrap");
        check("load_wrap.mem511", mem[511], 12'h123);
        check("load_wrap.mem0", mem[0], 12'h456);

        // Reset after one byte of a load: nothing written, no done.
        d0 = done_cnt; w0 = wr_cnt;
        @(negedge clk); cmd_load = 1; base = 9'd20; len = 10'd3;
        @(negedge clk); cmd_load = 0; rx_valid = 1; rx_data = 8'h0B;
        @(negedge clk); rx_valid = 0; rst = 1;
        check("abort.byte_taken", rx_take, 1);
        @(negedge clk); rst = 0;
        check("abort.busy", busy, 0);
        check("abort.rx_ready", rx_ready, 0);
        check("abort.mem_addr", mem_addr, 0);
        repeat (3) @(negedge clk);
        check("abort.no_done", done_cnt - d0, 0);
        check("abort.no_write", wr_cnt - w0, 0);
        src_q = '{8'h01, 8'h11, 8'h02, 8'h22};
        run_op(1, 0, 9'd20, 10'd2, 0, 0, "after_abort");
        check("after_abort.mem20", mem[20], 12'h111);

        run_op(1, 0, 9'd100, 10'd0, 0, 0, "load_len0");
        run_op(0, 0, 9'd100, 10'd0, 0, 0, "dump_len0");
        run_op(1, 1, 9'd40, 10'd3, 0, 0, "both_cmds");

        for (int k = 0; k < 30; k++) begin
            is_load = 1'($urandom_range(1));
            rl = ($urandom_range(3) == 0) ? (AW+1)'($urandom_range(9, 40)) : (AW+1)'($urandom_range(0, 8));
            run_op(is_load, 0, AW'($urandom), rl, $urandom_range(0, 60), 1, $sformatf("rand%0d", k));
        end

        run_op(1, 0, AW'($urandom), 10'd512, 0, 0, "load_full");
        run_op(0, 0, AW'($urandom), 10'd512, 20, 1, "dump_full");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
